// File: rtl/sha256_pkg.sv
// ============================================================================
// Module  : sha256_pkg
// Purpose : Shared SHA-256 message-schedule constants, FSM encoding and sigmas.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam int SHA256_WIN    = 16;
  localparam int SHA256_ROUNDS = 64;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_w_step.sv
// ============================================================================
// Module  : sha256_w_step
// Purpose : One combinational SHA-256 schedule step: W[t] from W[t-16..t-2].
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sha256_w_step
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] new_o
);

  assign new_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

`default_nettype wire

// File: rtl/sha256_w_sched_ctrl.sv
// ============================================================================
// Module  : sha256_w_sched_ctrl
// Purpose : Streams NUM_W SHA-256 schedule words per block over valid/ready.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sha256_w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         block_valid,
  input  logic [511:0] block_in,
  output logic         block_ready,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_W - 1);

  if (NUM_W < 17 || NUM_W > SHA256_ROUNDS) begin : g_bad_num_w
    $error("sha256_w_sched_ctrl: NUM_W must lie in 17..64");
  end

  sched_state_t state_q;
  logic [31:0]  win_q [SHA256_WIN];
  logic [5:0]   cnt_q;
  logic [5:0]   cnt_d;
  logic         done_q;
  logic [31:0]  w_new;
  logic         w_hs;

  sha256_w_step u_step (
    .w0_i  (win_q[0]),
    .w1_i  (win_q[1]),
    .w9_i  (win_q[9]),
    .w14_i (win_q[14]),
    .new_o (w_new)
  );

  assign w_hs  = (state_q == ST_RUN) && w_ready;
  assign cnt_d = cnt_q + 6'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < SHA256_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < SHA256_WIN; i++) begin
              win_q[i] <= block_in[511 - 32*i -: 32];
            end
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            for (int i = 0; i < SHA256_WIN - 1; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[SHA256_WIN-1] <= w_new;
            // The final handshake parks the counter at 0 so IDLE reads idx 0.
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign block_ready = (state_q == ST_IDLE);
  assign w_valid     = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign w_out       = (state_q == ST_RUN) ? win_q[0] : 32'd0;
  assign w_idx       = (state_q == ST_RUN) ? cnt_q : 6'd0;

endmodule

`default_nettype wire

// File: tb/tb_sha256_w_sched_ctrl.sv
// ============================================================================
// Module  : tb_sha256_w_sched_ctrl
// Purpose : Random-stimulus bench for the schedule streamer (NUM_W=64 and 17).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_w_sched_ctrl;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         bv [2];
  logic [511:0] bi [2];
  logic         br [2];
  logic         wv [2];
  logic         wr [2];
  logic [31:0]  wo [2];
  logic [5:0]   wi [2];
  logic         bz [2];
  logic         dn [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sha256_w_sched_ctrl #(.NUM_W(g == 0 ? 64 : 17)) u_dut (
      .CLK(CLK), .RST(RST), .block_valid(bv[g]), .block_in(bi[g]),
      .block_ready(br[g]), .w_valid(wv[g]), .w_ready(wr[g]), .w_out(wo[g]),
      .w_idx(wi[g]), .busy(bz[g]), .done(dn[g]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Transaction-level model: full FIPS 180-4 schedule per accepted block,
  // then a pointer into it that advances on each handshake.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int N = (g == 0) ? 64 : 17;
    logic [31:0] sched [64];
    logic [31:0] acc_words [64];
    logic [31:0] prev_out;
    bit          busy_m = 1'b0;
    bit          done_m = 1'b0;
    bit          stall_m = 1'b0;
    int          t_m = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;

    always @(negedge CLK) begin
      if (RST) begin
        check("rst_block_ready", 32'(br[g]), 32'd1);
        check("rst_w_valid", 32'(wv[g]), 32'd0);
        check("rst_busy", 32'(bz[g]), 32'd0);
        check("rst_done", 32'(dn[g]), 32'd0);
        check("rst_w_out", wo[g], 32'd0);
        check("rst_w_idx", 32'(wi[g]), 32'd0);
        busy_m  = 1'b0;
        done_m  = 1'b0;
        stall_m = 1'b0;
        t_m     = 0;
      end else begin
        check("block_ready", 32'(br[g]), 32'(!busy_m));
        check("w_valid", 32'(wv[g]), 32'(busy_m));
        check("busy", 32'(bz[g]), 32'(busy_m));
        check("done", 32'(dn[g]), 32'(done_m));
        if (dn[g]) done_cnt++;
        if (busy_m) begin
          check("w_out", wo[g], sched[t_m]);
          check("w_idx", 32'(wi[g]), 32'(t_m));
          if (stall_m) check("stall_stable", wo[g], prev_out);
        end else begin
          check("idle_w_out", wo[g], 32'd0);
          check("idle_w_idx", 32'(wi[g]), 32'd0);
        end
        done_m  = 1'b0;
        stall_m = 1'b0;
        if (busy_m) begin
          if (wr[g]) begin
            acc_words[t_m] = wo[g];
            acc_cnt++;
            if (t_m == N - 1) begin
              busy_m = 1'b0;
              done_m = 1'b1;
            end else begin
              t_m++;
            end
          end else begin
            stall_m  = 1'b1;
            prev_out = wo[g];
          end
        end else if (bv[g]) begin
          for (int i = 0; i < 64; i++) begin
            if (i < 16) sched[i] = bi[g][511 - 32*i -: 32];
            else sched[i] = m_s1(sched[i-2]) + sched[i-7] + m_s0(sched[i-15]) + sched[i-16];
          end
          busy_m = 1'b1;
          t_m    = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called just after the acceptance edge; cyc = cycle index of the done pulse.
  task automatic wait_done(input int g, input int bound, input bit rnd_rdy, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    for (int k = 1; k <= bound && !seen; k++) begin
      @(negedge CLK);
      if (dn[g]) begin
        seen = 1'b1;
        cyc  = k;
      end else begin
        tick();
        if (rnd_rdy) wr[g] = 1'($urandom_range(0, 1));
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_block(input int g, input logic [511:0] blk, input bit rnd_rdy, output int cyc);
    bi[g] = blk;
    bv[g] = 1'b1;
    tick();
    bv[g] = 1'b0;
    wait_done(g, 1000, rnd_rdy, cyc);
    wr[g] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int dbase;
    logic [31:0]  ref_w [64];
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    logic [511:0] blk_c;
    bit found;

    for (int g = 0; g < 2; g++) begin
      bv[g] = 1'b0;
      bi[g] = '0;
      wr[g] = 1'b1;
    end
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 32'(br[0]), 32'd1);
    tick();

    // "abc" block, no stalls
    base = g_mon[0].acc_cnt;
    run_block(0, ABC_BLK, 1'b0, cyc);
    check("abc_done_cycle", 32'(cyc), 32'd65);
    check("abc_count", 32'(g_mon[0].acc_cnt - base), 32'd64);
    check("abc_W0", g_mon[0].acc_words[0], 32'h61626380);
    check("abc_W15", g_mon[0].acc_words[15], 32'h00000018);
    check("abc_W16", g_mon[0].acc_words[16], 32'h61626380);
    check("abc_W17", g_mon[0].acc_words[17], 32'h000F0000);
    check("abc_W18", g_mon[0].acc_words[18], 32'h7DA86405);
    check("abc_W63", g_mon[0].acc_words[63], 32'h12B1EDEB);
    check("model_W63", g_mon[0].sched[63], 32'h12B1EDEB);
    for (int i = 0; i < 64; i++) ref_w[i] = g_mon[0].acc_words[i];
    tick();

    // same block with ~50% back-pressure
    base = g_mon[0].acc_cnt;
    run_block(0, ABC_BLK, 1'b1, cyc);
    check("stall_count", 32'(g_mon[0].acc_cnt - base), 32'd64);
    for (int i = 0; i < 64; i++) check("stall_word", g_mon[0].acc_words[i], ref_w[i]);
    tick();

    // back-to-back blocks with block_valid held
    blk_a = rnd_blk();
    blk_b = rnd_blk();
    bi[0] = blk_a;
    bv[0] = 1'b1;
    tick();
    bi[0] = blk_b;
    wait_done(0, 200, 1'b0, cyc);
    check("b2b_done_cycle", 32'(cyc), 32'd65);
    check("b2b_ready_in_done", 32'(br[0]), 32'd1);
    @(negedge CLK);
    check("b2b_second_valid", 32'(wv[0]), 32'd1);
    check("b2b_second_idx", 32'(wi[0]), 32'd0);
    check("b2b_second_W0", wo[0], blk_b[511:480]);
    tick();
    bv[0] = 1'b0;
    wait_done(0, 200, 1'b0, cyc);
    tick();

    // block_valid / block_in churn during RUN
    blk_c = rnd_blk();
    bi[0] = blk_c;
    bv[0] = 1'b1;
    tick();
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge CLK);
      if (dn[0]) begin
        found = 1'b1;
      end else begin
        tick();
        wr[0] = 1'($urandom_range(0, 1));
        bi[0] = rnd_blk();
        bv[0] = (wi[0] < 6'd60) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    check("churn_done_seen", 32'(found), 32'd1);
    check("churn_W0", g_mon[0].acc_words[0], blk_c[511:480]);
    check("churn_W15", g_mon[0].acc_words[15], blk_c[31:0]);
    bv[0] = 1'b0;
    wr[0] = 1'b1;
    tick();

    // asynchronous reset mid-block at w_idx 20
    bi[0] = rnd_blk();
    bv[0] = 1'b1;
    tick();
    bv[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK);
      if (wv[0] && wi[0] == 6'd20) found = 1'b1;
    end
    check("reach_idx20", 32'(found), 32'd1);
    dbase = g_mon[0].done_cnt;
    #2;
    RST = 1'b1;
    #1;
    check("async_w_valid", 32'(wv[0]), 32'd0);
    check("async_busy", 32'(bz[0]), 32'd0);
    check("async_w_out", wo[0], 32'd0);
    check("async_w_idx", 32'(wi[0]), 32'd0);
    check("async_ready", 32'(br[0]), 32'd1);
    check("async_done", 32'(dn[0]), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst2", 32'(br[0]), 32'd1);
    repeat (5) tick();
    check("rst_no_done", 32'(g_mon[0].done_cnt - dbase), 32'd0);
    base = g_mon[0].acc_cnt;
    bi[0] = rnd_blk();
    bv[0] = 1'b1;
    tick();
    bv[0] = 1'b0;
    @(negedge CLK);
    check("restart_valid", 32'(wv[0]), 32'd1);
    check("restart_idx0", 32'(wi[0]), 32'd0);
    tick();
    wait_done(0, 200, 1'b0, cyc);
    check("restart_count", 32'(g_mon[0].acc_cnt - base), 32'd64);
    tick();

    // NUM_W = 17 instance
    base = g_mon[1].acc_cnt;
    run_block(1, ABC_BLK, 1'b0, cyc);
    check("n17_done_cycle", 32'(cyc), 32'd18);
    check("n17_count", 32'(g_mon[1].acc_cnt - base), 32'd17);
    check("n17_W16", g_mon[1].acc_words[16], 32'h61626380);
    tick();
    base = g_mon[1].acc_cnt;
    run_block(1, rnd_blk(), 1'b1, cyc);
    check("n17_stall_count", 32'(g_mon[1].acc_cnt - base), 32'd17);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sha256_w_sched_ctrl.md
SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_W, default 64: number of schedule words emitted per block; legal range 17..64.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port block_valid, input, 1: block_in holds a valid 512-bit message block.
REQ-005 SHALL have port block_in, input, 512: message block; W0 = [511:480], W15 = [31:0].
REQ-006 SHALL have port block_ready, output, 1: the block can accept a new message block.
REQ-007 SHALL have port w_valid, output, 1: w_out and w_idx hold a valid schedule word.
REQ-008 SHALL have port w_ready, input, 1: the downstream compression stage accepts the word.
REQ-009 SHALL have port w_out, output, 32: schedule word W[w_idx].
REQ-010 SHALL have port w_idx, output, 6: index t of the word on w_out.
REQ-011 SHALL have port busy, output, 1: high while in RUN.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the last word is accepted.

Function
REQ-013 SHALL implement the two-state FSM IDLE/RUN; block_ready = (state==IDLE); w_valid = busy = (state==RUN).
REQ-014 SHALL, on block_valid&&block_ready, load a 16-word window win[0..15] = W0..W15, clear the counter to 0 and enter RUN on the next edge.
REQ-015 SHALL, in RUN, drive w_out = win[0] and w_idx = counter.
REQ-016 SHALL compute new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
REQ-017 SHALL, on each w_valid&&w_ready handshake, shift win[i] <= win[i+1] for i = 0..14, set win[15] <= new and increment the counter.
REQ-018 SHALL hold w_out, w_idx and the window stable while w_valid && !w_ready (stall); no word is skipped or repeated.
REQ-019 SHALL, on the handshake with counter == NUM_W-1, return to IDLE and assert done for exactly the following cycle.
  - block_ready is high in that same cycle.
  - There is a minimum of one idle cycle between blocks.
REQ-020 SHALL ignore block_valid while in RUN; block_in is sampled only at acceptance.
REQ-021 SHALL give first-word latency of exactly 1 cycle from the acceptance edge; with w_ready held high, words arrive 1 per cycle (NUM_W cycles per block).
REQ-022 SHALL drive w_out = 0 and w_idx = 0 in IDLE.

Reset
REQ-023 SHALL, on RST high, immediately force state = IDLE, counter = 0, window = 0, w_valid = busy = done = 0 and w_out = w_idx = 0, independent of CLK.
REQ-024 SHALL discard any in-flight block when RST is asserted mid-RUN; no done pulse is generated for it.
REQ-025 SHALL present block_ready = 1 on the first cycle after RST deasserts.

Structure
REQ-026 SHALL take the constants SHA256_WIN = 16, SHA256_ROUNDS = 64 and the sigma rotate/shift amounts from a shared package, sha256_pkg.
REQ-027 SHALL instantiate one combinational sub-module, sha256_w_step (inputs win[0], win[1], win[9], win[14]; output new), reusable by pipelined schedule stages.
REQ-028 SHALL keep the counter 6 bits wide, with no wrap inside a block because NUM_W <= 64.

Verification
REQ-029 SHALL cover the "abc" padded block with w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63 matching the golden model; done is asserted in cycle 65 after acceptance.
REQ-030 SHALL cover random w_ready stalls (50%) -> the 64 words are identical to the no-stall run and w_out is stable across every stall cycle.
REQ-031 SHALL cover two blocks offered back-to-back with block_valid held high -> the second is accepted in the done cycle and its W0 appears on the next cycle.
REQ-032 SHALL cover RST asserted at w_idx=20 -> outputs clear asynchronously, no done pulse, and a subsequent block restarts at w_idx=0.
REQ-033 SHALL cover block_valid toggling with changing block_in during RUN -> no effect on the output stream.
REQ-034 SHALL cover NUM_W=17 -> W16 is the last word and done is asserted after 17 handshakes.
